// File: rtl/mini_game_rng_if.sv
// ----------------------------------------------------------------------------
// mini_game_rng_if
// Request/response bundle between the game controller and the round-value
// generator.
//   enable     : 1 = generator runs and services requests, 0 = frozen
//   req        : single-cycle request for a new round value
//   seed_load  : load seed_in into the LFSR this cycle
//   seed_in    : 16-bit seed value
//   random_out : last accepted round value (0..MAX_VALUE), held between draws
//   valid      : one-cycle pulse when random_out updates
//   busy       : high while a draw is in progress
// Modports: master = game controller, slave = generator.
// ----------------------------------------------------------------------------
interface mini_game_rng_if;
    logic        enable;
    logic        req;
    logic        seed_load;
    logic [15:0] seed_in;
    logic [3:0]  random_out;
    logic        valid;
    logic        busy;

    modport master (
        output enable, req, seed_load, seed_in,
        input  random_out, valid, busy
    );

    modport slave (
        input  enable, req, seed_load, seed_in,
        output random_out, valid, busy
    );
endinterface

// File: rtl/mini_game_rng.sv
// ----------------------------------------------------------------------------
// mini_game_rng
// Round-value generator for the mini-game. A free-running 16-bit Galois LFSR
// (mask 16'hB400) is sampled on request; the low nibble is the candidate.
// Candidates above MAX_VALUE are rejected, and with NO_REPEAT a candidate equal
// to the previous output is rejected too (except the first draw after reset).
// After MAX_TRIES rejected evaluations the previous output is advanced by one
// (mod MAX_VALUE+1) so every request completes.
// Ports:
//   clk   : system clock
//   reset : synchronous, active-high reset
//   bus   : mini_game_rng_if.slave (enable, req, seed_load, seed_in in;
//           random_out, valid, busy out)
// ----------------------------------------------------------------------------
module mini_game_rng #(
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter int          MAX_VALUE = 14,
    parameter bit          NO_REPEAT = 1'b1,
    parameter int          MAX_TRIES = 8
) (
    input  logic           clk,
    input  logic           reset,
    mini_game_rng_if.slave bus
);

    localparam int             TRY_W    = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);
    localparam logic [3:0]     MAX_V    = 4'(MAX_VALUE);
    localparam logic [15:0]    LFSR_MASK = 16'hB400;

    typedef enum logic {
        IDLE = 1'b0,
        DRAW = 1'b1
    } state_t;

    state_t           state_q,  state_d;
    logic [15:0]      lfsr_q,   lfsr_d;
    logic [3:0]       random_q, random_d;
    logic             valid_q,  valid_d;
    logic [TRY_W-1:0] tries_q,  tries_d;
    logic             first_q,  first_d;

    logic [15:0] lfsr_step;
    logic [3:0]  cand;
    logic        accept;
    logic [3:0]  fallback;

    always_comb begin
        lfsr_step = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_MASK) : (lfsr_q >> 1);
        // Candidate is taken from the register value before this edge's step.
        cand      = lfsr_q[3:0];
        accept    = (cand <= MAX_V) &&
                    (!NO_REPEAT || first_q || (cand != random_q));
        // random_q never exceeds MAX_V, so wrapping at MAX_V is a true modulo.
        fallback  = (random_q == MAX_V) ? 4'd0 : (random_q + 4'd1);
    end

    always_comb begin
        state_d  = state_q;
        lfsr_d   = lfsr_q;
        random_d = random_q;
        valid_d  = 1'b0;
        tries_d  = tries_q;
        first_d  = first_q;

        if (bus.seed_load) begin
            // A zero seed would lock the LFSR at zero forever.
            lfsr_d  = (bus.seed_in == 16'h0000) ? SEED : bus.seed_in;
            state_d = IDLE;
            tries_d = '0;
        end else if (bus.enable) begin
            lfsr_d = lfsr_step;
            unique case (state_q)
                IDLE: begin
                    if (bus.req) begin
                        state_d = DRAW;
                        tries_d = '0;
                    end
                end
                DRAW: begin
                    if (accept) begin
                        random_d = cand;
                        valid_d  = 1'b1;
                        first_d  = 1'b0;
                        state_d  = IDLE;
                    end else if (tries_q == LAST_TRY) begin
                        random_d = fallback;
                        valid_d  = 1'b1;
                        first_d  = 1'b0;
                        state_d  = IDLE;
                    end else begin
                        tries_d = tries_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            lfsr_q   <= SEED;
            random_q <= 4'd0;
            valid_q  <= 1'b0;
            tries_q  <= '0;
            first_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            random_q <= random_d;
            valid_q  <= valid_d;
            tries_q  <= tries_d;
            first_q  <= first_d;
        end
    end

    assign bus.random_out = random_q;
    assign bus.valid      = valid_q;
    assign bus.busy       = (state_q == DRAW);

endmodule
